// File: rtl/multiplier_if.sv
// Operand/result bundle for the signed MULH multiplier.
// The full-product port p exists only when MULTIPLIER_FULL_EN is defined.
interface multiplier_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 in_valid;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 out_valid;
    logic [WIDTH-1:0]     y;
`ifdef MULTIPLIER_FULL_EN
    logic [2*WIDTH-1:0]   p;
`endif

    modport master (
        output in_valid,
        output A,
        output B,
        input  out_valid,
`ifdef MULTIPLIER_FULL_EN
        input  p,
`endif
        input  y
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        output out_valid,
`ifdef MULTIPLIER_FULL_EN
        output p,
`endif
        output y
    );
endinterface

// File: rtl/multiplier.sv
// Signed WIDTH x WIDTH shift-add multiplier returning the high product half, one register stage.
// Define MULTIPLIER_FULL_EN to also register and expose the full 2*WIDTH product on p.
module multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    multiplier_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] r_y;
    logic             r_out_valid;

    // Partial products of the sign-extended multiplicand; the MSB row carries weight
    // -2^(WIDTH-1), so it is subtracted. The sum is exact modulo 2^PW.
    always_comb begin
        w_a_ext = {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
        w_prod  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (bus.B[i]) begin
                if (i == int'(WIDTH) - 1) begin
                    w_prod = w_prod - (w_a_ext << i);
                end else begin
                    w_prod = w_prod + (w_a_ext << i);
                end
            end
        end
    end

`ifdef MULTIPLIER_FULL_EN
    logic [PW-1:0] r_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else if (bus.in_valid) begin
            r_p <= w_prod;
        end
    end

    assign bus.p = r_p;
`else
    logic w_unused;
    assign w_unused = ^w_prod[WIDTH-1:0];
`endif

    // y only loads on valid cycles, so X on idle operands never reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_y <= w_prod[PW-1:WIDTH];
            end
        end
    end

    assign bus.y         = r_y;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier at WIDTH=4: driver queues expected results, monitor checks them.
module tb_multiplier;
    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0]   y;
        logic [2*W-1:0] p;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    multiplier_if #(.WIDTH(W)) bus ();

    multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: whenever the DUT presents a result, pop and compare.
    always @(posedge clk) begin
        #2;
        if (bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got result y=%0h with empty scoreboard", bus.y);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("y", 32'(bus.y), 32'(e.y));
`ifdef MULTIPLIER_FULL_EN
                check_val("p", 32'(bus.p), 32'(e.p));
`endif
            end
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] y, input logic [2*W-1:0] p);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        e.y = y;
        e.p = p;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A        = 'x;
        bus.B        = 'x;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = 'x;
        bus.B        = 'x;
        #1;
        check_val("reset_y", 32'(bus.y), 32'h0);
        check_val("reset_out_valid", 32'(bus.out_valid), 32'h0);
`ifdef MULTIPLIER_FULL_EN
        check_val("reset_p", 32'(bus.p), 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Isolated vectors with idle gaps.
        drive(4'b0011, 4'b0011, 4'b0000, 8'h09);   // 3*3 = 9
        idle();
        drive(4'b1010, 4'b0011, 4'b1110, 8'hEE);   // -6*3 = -18
        idle();
        drive(4'b1111, 4'b0111, 4'b1111, 8'hF9);   // -1*7 = -7
        drive(4'b0010, 4'b0101, 4'b0000, 8'h0A);   // 2*5 = 10
        idle();
        drive(4'b1000, 4'b0111, 4'b1100, 8'hC8);   // -8*7 = -56
        drive(4'b1000, 4'b1000, 4'b0100, 8'h40);   // -8*-8 = 64
        drive(4'b0000, 4'b1011, 4'b0000, 8'h00);   // 0*-5 = 0
        drive(4'b0111, 4'b1000, 4'b1100, 8'hC8);   // 7*-8 = -56
        idle();

        // Back-to-back stream; any out_valid gap leaves entries in the scoreboard.
        drive(4'b0011, 4'b0011, 4'b0000, 8'h09);
        drive(4'b1010, 4'b0011, 4'b1110, 8'hEE);
        drive(4'b1111, 4'b0111, 4'b1111, 8'hF9);
        drive(4'b0010, 4'b0101, 4'b0000, 8'h0A);
        drive(4'b1000, 4'b0111, 4'b1100, 8'hC8);
        drive(4'b1000, 4'b1000, 4'b0100, 8'h40);
        idle();
        @(posedge clk);
        #2;
        check_val("stream_drained", 32'(sb_q.size()), 32'h0);
        check_val("idle_out_valid", 32'(bus.out_valid), 32'h0);
        check_val("idle_y_hold", 32'(bus.y), 32'h4);
        @(posedge clk);
        #2;
        check_val("idle_y_hold2", 32'(bus.y), 32'h4);

        // Asynchronous reset between edges discards a pending operand pair.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A        = 4'b1010;
        bus.B        = 4'b0011;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_y", 32'(bus.y), 32'h0);
        check_val("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
`ifdef MULTIPLIER_FULL_EN
        check_val("async_rst_p", 32'(bus.p), 32'h0);
`endif
        @(posedge clk);
        #2;
        check_val("held_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_val("held_rst_y", 32'(bus.y), 32'h0);

        // Release reset together with a valid pair: the first edge yields a result.
        @(negedge clk);
        rst_n = 1'b1;
        begin
            exp_t e;
            bus.in_valid = 1'b1;
            bus.A        = 4'b1010;
            bus.B        = 4'b0011;
            e.y = 4'b1110;
            e.p = 8'hEE;
            sb_q.push_back(e);
        end
        idle();
        @(posedge clk);
        #3;
        check_val("final_drained", 32'(sb_q.size()), 32'h0);
        check_val("final_y_hold", 32'(bus.y), 32'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
